fft_bitrev_reorder: RTL

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

---
 rtl/fft_pkg.sv | 33 +++
 rtl/fft_pingpong_ram.sv | 30 +++
 rtl/fft_bitrev_reorder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: ping-pong bank states, log2 helper and bit-reversal.
package fft_pkg;

    localparam int MAX_LOG2N = 12;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    function automatic int log2_int(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Reverses the low 'bits' bits of idx; 'bits' is a constant at every call site.
    function automatic logic [MAX_LOG2N-1:0] bit_reverse(input logic [MAX_LOG2N-1:0] idx,
                                                         input int bits);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < bits) r[bits-1-i] = idx[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two banks of N complex samples; one write port and one registered read port.
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 256,
    localparam int LOG2N = log2_int(N)
) (
    input  logic                 clock,
    input  logic                 write_en,
    input  logic                 write_bank,
    input  logic [LOG2N-1:0]     write_addr,
    input  logic [2*WIDTH-1:0]   write_data,
    input  logic                 read_en,
    input  logic                 read_bank,
    input  logic [LOG2N-1:0]     read_addr,
    output logic [2*WIDTH-1:0]   read_data
);

    logic [2*WIDTH-1:0] mem [2*N];

    always_ff @(posedge clock) begin
        if (write_en) mem[{write_bank, write_addr}] <= write_data;
    end

    always_ff @(posedge clock) begin
        if (read_en) read_data <= mem[{read_bank, read_addr}];
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong frame buffer that drains each FFT frame in bit-reversed or natural order.
//
// bank state    | meaning
// BANK_EMPTY    | no valid data, free for the writer
// BANK_FILLING  | writer has stored at least one sample of the frame
// BANK_FULL     | all N samples stored, drain starts on the next edge
// BANK_DRAINING | reader is walking the frame out
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 256,
    localparam int LOG2N = log2_int(N)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               input_en,
    input  logic [WIDTH-1:0]   input_real,
    input  logic [WIDTH-1:0]   input_imag,
    input  logic               reorder_en,
    output logic               output_en,
    output logic [WIDTH-1:0]   output_real,
    output logic [WIDTH-1:0]   output_imag,
    output logic [LOG2N-1:0]   output_index,
    output logic               output_last
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    bank_state_t        bank_q [2];
    bank_state_t        bank_d [2];
    logic [LOG2N-1:0]   wr_cnt;
    logic [LOG2N-1:0]   rd_cnt;
    logic [LOG2N-1:0]   rd_addr;
    logic               wr_bank;
    logic               rd_bank;
    logic [1:0]         bank_reorder;
    logic               rd_go;
    logic               rd_last;
    logic               wr_last;
    logic               p1_valid;
    logic [LOG2N-1:0]   p1_index;
    logic [2*WIDTH-1:0] rd_data;

    assign rd_go   = (bank_q[rd_bank] == BANK_FULL) || (bank_q[rd_bank] == BANK_DRAINING);
    assign rd_last = rd_go && (rd_cnt == LAST_IDX);
    assign wr_last = input_en && (wr_cnt == LAST_IDX);
    assign rd_addr = bank_reorder[rd_bank] ? LOG2N'(bit_reverse(MAX_LOG2N'(rd_cnt), LOG2N))
                                           : rd_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
        end
    end

    // Reader and writer never act on the same bank, so write updates may override safely.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        if (rd_go) bank_d[rd_bank] = rd_last ? BANK_EMPTY : BANK_DRAINING;
        if (input_en) bank_d[wr_bank] = wr_last ? BANK_FULL : BANK_FILLING;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_cnt       <= '0;
            wr_bank      <= 1'b0;
            bank_reorder <= '0;
            rd_cnt       <= '0;
            rd_bank      <= 1'b0;
            p1_valid     <= 1'b0;
            p1_index     <= '0;
        end else begin
            if (input_en) begin
                if (wr_cnt == '0) bank_reorder[wr_bank] <= reorder_en;
                wr_cnt <= wr_cnt + LOG2N'(1);
                if (wr_last) wr_bank <= ~wr_bank;
            end
            if (rd_go) begin
                rd_cnt <= rd_cnt + LOG2N'(1);
                if (rd_last) rd_bank <= ~rd_bank;
            end
            p1_valid <= rd_go;
            p1_index <= rd_cnt;
        end
    end

    fft_pingpong_ram #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_ram (
        .clock      (clock),
        .write_en   (input_en),
        .write_bank (wr_bank),
        .write_addr (wr_cnt),
        .write_data ({input_real, input_imag}),
        .read_en    (rd_go),
        .read_bank  (rd_bank),
        .read_addr  (rd_addr),
        .read_data  (rd_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            output_en    <= 1'b0;
            output_last  <= 1'b0;
            output_index <= '0;
            output_real  <= '0;
            output_imag  <= '0;
        end else begin
            output_en    <= p1_valid;
            output_last  <= p1_valid && (p1_index == LAST_IDX);
            output_index <= p1_valid ? p1_index : '0;
            output_real  <= p1_valid ? rd_data[2*WIDTH-1:WIDTH] : '0;
            output_imag  <= p1_valid ? rd_data[WIDTH-1:0] : '0;
        end
    end

endmodule
